// File: rtl/dino_game_pkg.sv
// Shared constants for the dino game video path.
// Holds the byte type, screen extents, scene geometry, obstacle height range,
// the 3-bit {R,G,B} colour palette and the non-running screen codes.
// A small rectangle hit-test helper is shared by the renderers.
package dino_game_pkg;

   localparam int UBYTE_W = 8;
   typedef logic [UBYTE_W-1:0] ubyte_t;

   localparam ubyte_t xMAX      = 8'd159;
   localparam ubyte_t yMAX      = 8'd119;

   localparam ubyte_t groundTop = 8'd100;
   localparam ubyte_t dinoX     = 8'd20;
   localparam ubyte_t dinoW     = 8'd10;
   localparam ubyte_t dinoH     = 8'd12;
   localparam ubyte_t minObsH   = 8'd8;
   localparam ubyte_t maxObsH   = 8'd20;
   localparam ubyte_t obsW      = 8'd6;

   typedef logic [2:0] color_t;
   localparam color_t colBG     = 3'b111;
   localparam color_t colGround = 3'b000;
   localparam color_t colDino   = 3'b010;
   localparam color_t colObs    = 3'b100;
   localparam color_t colTitle  = 3'b001;
   localparam color_t colText   = 3'b000;
   localparam color_t colBanner = 3'b100;

   localparam int SCREEN_MENU  = 0;
   localparam int SCREEN_PAUSE = 1;
   localparam int SCREEN_OVER  = 2;

   // Inclusive rectangle test with constant bounds; all operands are 8 bits
   // and nothing is added, so no widening is needed here.
   function automatic logic in_rect(input ubyte_t px, input ubyte_t py,
                                    input ubyte_t x0, input ubyte_t x1,
                                    input ubyte_t y0, input ubyte_t y1);
      return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
   endfunction

endpackage

// File: rtl/game_scene_shapes.sv
// Combinational hit tests for the moving scene: dino, two obstacles, ground.
// Ports:
//   x, y            pixel coordinate under test
//   dinoY           top row of the dino sprite
//   obs1X, obs1H    obstacle 1 left column and height (X > 159 is off-screen)
//   obs2X, obs2H    obstacle 2 left column and height
//   hitDino/hitObs1/hitObs2/hitGround   pixel lies inside that shape
// All edge arithmetic is done in 9 bits so an obstacle parked near 255 can
// never wrap back onto the left of the screen.
module game_scene_shapes
   import dino_game_pkg::*;
(
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic [7:0] dinoY,
   input  logic [7:0] obs1X,
   input  logic [7:0] obs1H,
   input  logic [7:0] obs2X,
   input  logic [7:0] obs2H,
   output logic       hitDino,
   output logic       hitObs1,
   output logic       hitObs2,
   output logic       hitGround
);

   localparam logic [8:0] GROUND_LO  = {1'b0, groundTop};
   localparam logic [8:0] GROUND_HI  = {1'b0, groundTop} + 9'd1;
   localparam logic [8:0] DINO_X_LO  = {1'b0, dinoX};
   localparam logic [8:0] DINO_X_HI  = {1'b0, dinoX} + {1'b0, dinoW} - 9'd1;
   localparam logic [8:0] DINO_H_M1  = {1'b0, dinoH} - 9'd1;
   localparam logic [8:0] OBS_W_M1   = {1'b0, obsW} - 9'd1;

   logic [8:0] x9;
   logic [8:0] y9;
   logic [8:0] dino_top;
   logic [8:0] dino_bot;

   // A tall obstacle clamps its top to row 0 instead of going negative.
   // Height 0 leaves top = groundTop, above the bottom row, so it draws nothing.
   function automatic logic obs_hit(input logic [8:0] px, input logic [8:0] py,
                                    input logic [7:0] ox, input logic [7:0] oh);
      logic [8:0] left;
      logic [8:0] right;
      logic [8:0] top;
      left  = {1'b0, ox};
      right = {1'b0, ox} + OBS_W_M1;
      top   = (oh >= groundTop) ? 9'd0 : (GROUND_LO - {1'b0, oh});
      return (px >= left) && (px <= right) &&
             (py >= top) && (py <= GROUND_LO - 9'd1);
   endfunction

   always_comb begin
      x9        = {1'b0, x};
      y9        = {1'b0, y};
      dino_top  = {1'b0, dinoY};
      dino_bot  = {1'b0, dinoY} + DINO_H_M1;
      hitDino   = (x9 >= DINO_X_LO) && (x9 <= DINO_X_HI) &&
                  (y9 >= dino_top) && (y9 <= dino_bot);
      hitObs1   = obs_hit(x9, y9, obs1X, obs1H);
      hitObs2   = obs_hit(x9, y9, obs2X, obs2H);
      hitGround = (y9 >= GROUND_LO) && (y9 <= GROUND_HI);
   end

endmodule

// File: rtl/game_screen_renderer.sv
// Per-pixel colour for the non-running screens (menu, pause, game over).
// Parameter SCREEN: 0 menu, 1 pause, 2 game over, anything else background.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   frameClk        one-clk pulse per frame, advances the blink counter
//   x, y            pixel coordinate
//   dinoY, obs1X/H, obs2X/H   frame-snapshotted scene state
//   color           {R,G,B}, combinational from the inputs and blink counter
// Priority: overlay, dino, obstacle 1, obstacle 2, ground, background.
module game_screen_renderer
   import dino_game_pkg::*;
#(
   parameter int SCREEN = 0
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       frameClk,
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic [7:0] dinoY,
   input  logic [7:0] obs1X,
   input  logic [7:0] obs2X,
   input  logic [7:0] obs1H,
   input  logic [7:0] obs2H,
   output logic [2:0] color
);

   localparam logic SCENE_EN = (SCREEN == SCREEN_MENU) ||
                               (SCREEN == SCREEN_PAUSE) ||
                               (SCREEN == SCREEN_OVER);
   // Obstacles belong to a game in progress, so the menu hides them.
   localparam logic SHOW_OBS = (SCREEN == SCREEN_PAUSE) ||
                               (SCREEN == SCREEN_OVER);

   logic [7:0] blink_q;
   logic [7:0] blink_d;
   logic       blink_on;

   logic       hit_dino;
   logic       hit_obs1;
   logic       hit_obs2;
   logic       hit_ground;

   logic       overlay_hit;
   color_t     overlay_col;

   always_comb begin
      blink_d = blink_q;
      if (frameClk) begin
         blink_d = blink_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_q <= 8'd0;
      end else begin
         blink_q <= blink_d;
      end
   end

   // Bit 4 low means the blinking elements are visible: 16 frames on, 16 off.
   assign blink_on = ~blink_q[4];

   game_scene_shapes u_shapes (
      .x         (x),
      .y         (y),
      .dinoY     (dinoY),
      .obs1X     (obs1X),
      .obs1H     (obs1H),
      .obs2X     (obs2X),
      .obs2H     (obs2H),
      .hitDino   (hit_dino),
      .hitObs1   (hit_obs1),
      .hitObs2   (hit_obs2),
      .hitGround (hit_ground)
   );

   generate
      case (SCREEN)
         SCREEN_MENU: begin : g_menu
            always_comb begin
               overlay_hit = 1'b0;
               overlay_col = colBG;
               if (in_rect(x, y, 8'd40, 8'd119, 8'd20, 8'd39)) begin
                  overlay_hit = 1'b1;
                  overlay_col = colTitle;
               end else if (blink_on && in_rect(x, y, 8'd50, 8'd109, 8'd50, 8'd57)) begin
                  overlay_hit = 1'b1;
                  overlay_col = colText;
               end
            end
         end
         SCREEN_PAUSE: begin : g_pause
            always_comb begin
               overlay_hit = 1'b0;
               overlay_col = colBG;
               if (in_rect(x, y, 8'd74, 8'd77, 8'd40, 8'd59) ||
                   in_rect(x, y, 8'd82, 8'd85, 8'd40, 8'd59)) begin
                  overlay_hit = 1'b1;
                  overlay_col = colText;
               end
            end
         end
         SCREEN_OVER: begin : g_over
            // The inner strip punches a background-coloured hole in the banner.
            always_comb begin
               overlay_hit = 1'b0;
               overlay_col = colBG;
               if (blink_on && in_rect(x, y, 8'd40, 8'd119, 8'd37, 8'd42)) begin
                  overlay_hit = 1'b1;
                  overlay_col = colBG;
               end else if (in_rect(x, y, 8'd30, 8'd129, 8'd30, 8'd49)) begin
                  overlay_hit = 1'b1;
                  overlay_col = colBanner;
               end
            end
         end
         default: begin : g_blank
            assign overlay_hit = 1'b0;
            assign overlay_col = colBG;
         end
      endcase
   endgenerate

   always_comb begin
      color = colBG;
      if (!SCENE_EN) begin
         color = colBG;
      end else if (overlay_hit) begin
         color = overlay_col;
      end else if (hit_dino) begin
         color = colDino;
      end else if (SHOW_OBS && hit_obs1) begin
         color = colObs;
      end else if (SHOW_OBS && hit_obs2) begin
         color = colObs;
      end else if (hit_ground) begin
         color = colGround;
      end
   end

endmodule

// File: tb/tb_game_screen_renderer.sv
// Directed bench for game_screen_renderer: one instance per screen code
// (menu, pause, game over, unused code 3) sharing all inputs.
module tb_game_screen_renderer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frameClk = 1'b0;
   logic [7:0] x = 8'd0;
   logic [7:0] y = 8'd0;
   logic [7:0] dinoY = 8'd88;
   logic [7:0] obs1X = 8'd200;
   logic [7:0] obs2X = 8'd200;
   logic [7:0] obs1H = 8'd0;
   logic [7:0] obs2H = 8'd0;
   logic [2:0] color_menu;
   logic [2:0] color_pause;
   logic [2:0] color_over;
   logic [2:0] color_blank;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   game_screen_renderer #(.SCREEN(0)) dut_menu (
      .clk(clk), .reset(reset), .frameClk(frameClk), .x(x), .y(y),
      .dinoY(dinoY), .obs1X(obs1X), .obs2X(obs2X), .obs1H(obs1H), .obs2H(obs2H),
      .color(color_menu));
   game_screen_renderer #(.SCREEN(1)) dut_pause (
      .clk(clk), .reset(reset), .frameClk(frameClk), .x(x), .y(y),
      .dinoY(dinoY), .obs1X(obs1X), .obs2X(obs2X), .obs1H(obs1H), .obs2H(obs2H),
      .color(color_pause));
   game_screen_renderer #(.SCREEN(2)) dut_over (
      .clk(clk), .reset(reset), .frameClk(frameClk), .x(x), .y(y),
      .dinoY(dinoY), .obs1X(obs1X), .obs2X(obs2X), .obs1H(obs1H), .obs2H(obs2H),
      .color(color_over));
   game_screen_renderer #(.SCREEN(3)) dut_blank (
      .clk(clk), .reset(reset), .frameClk(frameClk), .x(x), .y(y),
      .dinoY(dinoY), .obs1X(obs1X), .obs2X(obs2X), .obs1H(obs1H), .obs2H(obs2H),
      .color(color_blank));

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Move the pixel away from the clock edge and let the combinational path settle.
   task automatic set_xy(input int px, input int py);
      @(negedge clk);
      x = px[7:0];
      y = py[7:0];
      #1;
   endtask

   task automatic frame_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         frameClk = 1'b1;
         @(negedge clk);
         frameClk = 1'b0;
      end
   endtask

   initial begin
      // Reset: blink = 0, prompt visible.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      set_xy(60, 52);
      check("menu_prompt_reset", color_menu, 3'b000);
      frame_pulses(16);
      set_xy(60, 52);
      check("menu_prompt_off", color_menu, 3'b111);
      frame_pulses(16);
      set_xy(60, 52);
      check("menu_prompt_on_again", color_menu, 3'b000);
      set_xy(40, 20);
      check("menu_title_corner", color_menu, 3'b001);
      set_xy(25, 90);
      check("menu_dino", color_menu, 3'b010);

      // Pause screen, dino standing on the ground (dinoY = 88).
      set_xy(25, 90);
      check("pause_dino", color_pause, 3'b010);
      check("blank_screen_bg", color_blank, 3'b111);
      set_xy(25, 100);
      check("pause_ground", color_pause, 3'b000);
      set_xy(75, 45);
      check("pause_bar", color_pause, 3'b000);
      set_xy(79, 45);
      check("pause_gap", color_pause, 3'b111);

      // Obstacle 1 at 120, height 8: covers x 120..125, y 92..99.
      obs1X = 8'd120;
      obs1H = 8'd8;
      set_xy(120, 92);
      check("obs1_top_left", color_pause, 3'b100);
      set_xy(125, 99);
      check("obs1_bot_right", color_pause, 3'b100);
      set_xy(126, 99);
      check("obs1_right_edge", color_pause, 3'b111);
      set_xy(120, 91);
      check("obs1_above", color_pause, 3'b111);
      set_xy(120, 95);
      check("menu_no_obs", color_menu, 3'b111);
      check("over_obs", color_over, 3'b100);

      // Obstacle 2 parked at 254 must not wrap onto the left edge.
      obs1X = 8'd200;
      obs2X = 8'd254;
      obs2H = 8'd20;
      for (int i = 0; i <= 159; i++) begin
         set_xy(i, 95);
         check("obs2_offscreen", color_pause, (i >= 20 && i <= 29) ? 3'b010 : 3'b111);
      end
      obs1X = 8'd157;
      obs1H = 8'd8;
      set_xy(159, 95);
      check("obs1_right_screen_edge", color_pause, 3'b100);

      // Tall obstacle clamps at row 0; zero height draws nothing.
      obs1X = 8'd120;
      obs1H = 8'd150;
      set_xy(122, 0);
      check("obs1_clamped_top", color_pause, 3'b100);
      obs1H = 8'd0;
      set_xy(122, 99);
      check("obs1_zero_height", color_pause, 3'b111);

      // Game over, blink = 32 so the strip is visible.
      obs1X = 8'd200;
      obs2X = 8'd200;
      obs2H = 8'd0;
      set_xy(35, 35);
      check("over_banner", color_over, 3'b100);
      set_xy(60, 40);
      check("over_strip_on", color_over, 3'b111);
      // An obstacle under the strip is hidden by the overlay.
      obs1X = 8'd60;
      obs1H = 8'd80;
      set_xy(60, 40);
      check("over_strip_over_obs", color_over, 3'b111);
      obs1X = 8'd200;
      obs1H = 8'd0;
      dinoY = 8'd30;
      set_xy(25, 35);
      check("over_dino_beside_banner", color_over, 3'b010);
      dinoY = 8'd88;
      frame_pulses(16);
      set_xy(60, 40);
      check("over_strip_off", color_over, 3'b100);

      // blink = 48 (prompt off); reset with frameClk must give blink = 0.
      set_xy(60, 52);
      check("menu_prompt_off_48", color_menu, 3'b111);
      @(negedge clk);
      reset = 1'b1;
      frameClk = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      frameClk = 1'b0;
      set_xy(60, 52);
      check("reset_beats_frame", color_menu, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/game_screen_renderer.md
# game_screen_renderer

Combinational per-pixel colour generator for the non-running game screens: main menu, pause and game over. It maps the pixel coordinate chosen by the pixel scanner, plus the frame-snapshotted dino and obstacle state, to a 3-bit RGB colour. The state-based colour mux selects this output while the game is in the matching state. One parameterised module replaces three hand-written renderers (menu, pause, over).

## Interface
- `SCREEN`, default 0: selects the screen. 0 = menu, 1 = pause, 2 = game over; other values render background only.
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset. The integrator ties it to `~resetn`.
- `frameClk`  in  1  one-`clk`-wide pulse per frame.
- `x`  in  8  pixel column, 0..`xMAX` (159).
- `y`  in  8  pixel row, 0..`yMAX` (119).
- `dinoY`  in  8  top row of the dino sprite.
- `obs1X`, `obs2X`  in  8  left column of obstacles 1 and 2. Values above 159 mean off-screen.
- `obs1H`, `obs2H`  in  8  obstacle heights in pixels.
- `color`  out  3  {R,G,B} colour for (x,y).

## Operation
- Fixed constants: `groundTop`=100, `dinoX`=20, `dinoW`=10, `dinoH`=12, obstacle width 6.
- Colour constants: `colBG`=3'b111, `colGround`=3'b000, `colDino`=3'b010, `colObs`=3'b100, `colTitle`=3'b001, `colText`=3'b000, `colBanner`=3'b100.
- Hit tests; all bounds are inclusive.
  - Ground: y in [groundTop, groundTop+1].
  - Dino: x in [dinoX, dinoX+dinoW-1] and y in [dinoY, dinoY+dinoH-1].
  - Obstacle n: x in [obsnX, obsnX+5] and y in [groundTop-obsnH, groundTop-1].
- Width rules for the hit tests:
  - All sums and differences are computed in 9-bit unsigned, or signed where subtracting. Nothing may wrap to 8 bits.
  - obsX=254 therefore never covers any visible x.
  - If obsH ≥ groundTop, the obstacle top clamps to row 0.
  - obsH=0 draws nothing.
- Frame counter:
  - `blink`, 8 bits, increments on each `clk` edge where `frameClk`=1.
  - Wraps 255→0.
  - Blink phase `on` = (`blink[4]`==0), i.e. it toggles every 16 frames.
- Menu (SCREEN=0):
  - Title rectangle x 40..119, y 20..39 → colTitle.
  - Start prompt x 50..109, y 50..57 → colText, drawn only while `on`.
  - Below those: dino, then ground, then background.
  - Obstacles are not drawn on the menu.
- Pause (SCREEN=1):
  - Pause icon bars x 74..77 and x 82..85, both y 40..59 → colText. The bars are always drawn.
  - Below those: dino, obstacles, ground, background.
- Game over (SCREEN=2):
  - Banner x 30..129, y 30..49 → colBanner.
  - Inner text strip x 40..119, y 37..42 → colBG, drawn only while `on`.
  - Below those: dino, obstacles, ground, background.
- Priority for every screen, highest first: overlay, dino, obstacle 1, obstacle 2, ground, background (colBG).
- Input coordinates outside 0..159 / 0..119 still evaluate the hit tests normally; the scanner never drives them.

## Timing
- `color` is purely combinational from x, y, the snapshot inputs and `blink`, with zero latency. The caller's one-cycle plot/settle handshake therefore always sees a colour matching the current x,y.
- `blink` is the only state. It updates on the `clk` edge where `frameClk`=1, so its effect on `color` appears the following cycle.
- Reset: `blink` becomes 0, so `on`=1. `color` is then the combinational result with `on`=1.
- `reset` and `frameClk` asserted in the same cycle: reset wins and `blink` becomes 0.
- Reset asserted mid-frame takes effect on the next edge. No output glitch handling is required.

## Structure
- Shared package `dino_game_pkg`:
  - ubyte width (8);
  - `xMAX`/`yMAX`;
  - `groundTop`, `dinoX`/`dinoW`/`dinoH`, `minObsH`=8, `maxObsH`=20, obstacle width;
  - all colour constants;
  - SCREEN codes.
- Sub-module `game_scene_shapes`:
  - combinational;
  - inputs x, y, dinoY, obs1X/H, obs2X/H;
  - outputs `hitDino`, `hitObs1`, `hitObs2`, `hitGround`.
  - It is shared with the running-game renderer.
- Overlay rectangles and priority mux sit in the top module, selected by a `generate`/`case` on SCREEN.

## Test plan
- Reset with SCREEN=0, x=60, y=52 → color=3'b000 (prompt visible). Then apply 16 `frameClk` pulses → color=3'b111. Apply 16 more → 3'b000.
- SCREEN=1, dinoY=88 (=groundTop−dinoH), x=25, y=90 → 3'b010. Same dinoY, x=25, y=100 → 3'b000. x=75, y=45 → 3'b000. x=79, y=45 → 3'b111.
- SCREEN=1, obs1X=120, obs1H=8: x=120, y=92 → 3'b100; x=125, y=99 → 3'b100; x=126, y=99 → 3'b111; x=120, y=91 → 3'b111.
- obs2X=254, obs2H=20, every x 0..159 at y=95 → never 3'b100. obs1X=157, obs1H=8: x=159, y=95 → 3'b100.
- SCREEN=2 with `on`: x=35, y=35 → 3'b100; x=60, y=40 → 3'b111. After 16 frame pulses, x=60, y=40 → 3'b100. Dino overlapping the banner area shows the banner colour.
- SCREEN=0 with obs1X=120, obs1H=8: x=120, y=95 → 3'b111. `reset` together with `frameClk` → `blink`=0.
